uart_tx_arbiter: RTL and testbench

Shares one UART transmitter among N_REQ byte producers using round-robin arbitration. It sits between the requesters and the transmitter's `start`/`busy` handshake. It latches the winning requester's byte, holds `tx_start` until the transmitter raises `busy`, then waits for `busy` to fall before arbitrating again. A start timeout keeps a dead transmitter from stalling the arbiter.

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter handshake bundle for the UART TX arbiter
interface uart_tx_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            ack;
    logic [DATA_WIDTH-1:0]       tx_data;
    logic                        tx_start;
    logic                        tx_busy;
    logic [GW-1:0]               grant_id;
    logic                        arb_busy;
    logic                        done;
    logic                        timeout_err;

    // Requesters plus transmitter side
    modport master (
        output req, req_data, tx_busy,
        input  ack, tx_data, tx_start, grant_id, arb_busy, done, timeout_err
    );

    // Arbiter side
    modport slave (
        input  req, req_data, tx_busy,
        output ack, tx_data, tx_start, grant_id, arb_busy, done, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N_REQ producers
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_arbiter_if.slave   bus
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(START_TIMEOUT);
    localparam logic [GW-1:0] LAST_RST = GW'(N_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_START,
        ST_SEND
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [N_REQ-1:0]        ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_start_q, tx_start_d;
    logic [GW-1:0]           grant_id_q, grant_id_d;
    logic                    arb_busy_q, arb_busy_d;
    logic                    done_q, done_d;
    logic                    timeout_q, timeout_d;

    logic                    found;
    logic [GW-1:0]           pick;
    logic [GW-1:0]           cand;
    logic [DATA_WIDTH-1:0]   pick_data;

    // Round-robin search: first set request after the last granted index, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = GW'((int'(last_q) + k) % N_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Select the winning requester's byte with constant slices
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == GW'(i)) begin
                pick_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and registered-output logic; pulses default low every cycle
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        grant_id_d = grant_id_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (found) begin
                    tx_data_d   = pick_data;
                    grant_id_d  = pick;
                    last_d      = pick;
                    ack_d[pick] = 1'b1;
                    tx_start_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                cnt_d = cnt_q + 1'b1;
                // A busy flag arriving on the last allowed cycle still wins
                if (bus.tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_SEND;
                end else if (cnt_q == CNT_LAST) begin
                    tx_start_d = 1'b0;
                    timeout_d  = 1'b1;
                    state_d    = ST_ARB;
                end
            end
            ST_SEND: begin
                if (!bus.tx_busy) begin
                    done_d  = 1'b1;
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        arb_busy_d = (state_d != ST_ARB);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ARB;
            last_q     <= LAST_RST;
            cnt_q      <= '0;
            ack_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            grant_id_q <= '0;
            arb_busy_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            grant_id_q <= grant_id_d;
            arb_busy_q <= arb_busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.arb_busy    = arb_busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .START_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter model
    logic tx_busy_r = 1'b0;
    bit   tx_dead   = 1'b0;
    bit   tx_rand   = 1'b0;
    int   tx_dly    = 1;
    int   tx_len    = 10;
    int   tx_wait   = 1;
    int   tx_rem    = 0;
    assign bus.tx_busy = tx_busy_r;

    function automatic int pick_dly();
        int r;
        r = $urandom_range(0, 11);
        if (r < 7)  return r % 4;
        if (r == 7) return 15;
        if (r == 8) return 16;
        if (r == 9) return 14;
        if (r == 10) return 22;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            tx_busy_r = 1'b0;
            tx_rem    = 0;
            tx_wait   = tx_dly;
        end else if (tx_busy_r) begin
            tx_rem--;
            if (tx_rem <= 0) tx_busy_r = 1'b0;
        end else if (bus.tx_start && !tx_dead) begin
            if (tx_wait == 0) begin
                tx_busy_r = 1'b1;
                tx_rem    = tx_rand ? int'($urandom_range(1, 12)) : tx_len;
            end else begin
                tx_wait--;
            end
        end else begin
            tx_wait = tx_rand ? pick_dly() : tx_dly;
        end
    end

    // Behavioural reference: phase of the current byte and age since start rose
    int             m_phase;   // 0 idle, 1 waiting for busy, 2 transmitting
    int             m_last;
    int             m_age;
    logic [N-1:0]   e_ack;
    logic [DW-1:0]  e_data;
    logic           e_start;
    int             e_gid;
    logic           e_done;
    logic           e_to;

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_last = N - 1; m_age = 0;
        e_ack = '0; e_data = '0; e_start = 1'b0; e_gid = 0; e_done = 1'b0; e_to = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N*DW-1:0] rd, input logic busy);
        int g;
        e_ack  = '0;
        e_done = 1'b0;
        e_to   = 1'b0;
        if (m_phase == 0) begin
            g = rr_pick(m_last, r);
            if (g >= 0) begin
                m_last  = g;
                e_gid   = g;
                e_data  = rd[g*DW +: DW];
                e_ack   = N'(1) << g;
                e_start = 1'b1;
                m_age   = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_age++;
            if (busy) begin
                e_start = 1'b0;
                m_phase = 2;
            end else if (m_age == TO) begin
                e_start = 1'b0;
                e_to    = 1'b1;
                m_phase = 0;
            end
        end else begin
            if (!busy) begin
                e_done  = 1'b1;
                m_phase = 0;
            end
        end
    endtask

    // Single compare process: update model at the edge, compare 1 time unit later
    always @(posedge clk) begin
        if (!reset) model_reset();
        else        model_step(bus.req, bus.req_data, bus.tx_busy);
        #1;
        check("ack",         bus.ack,         e_ack);
        check("tx_data",     bus.tx_data,     e_data);
        check("tx_start",    bus.tx_start,    e_start);
        check("grant_id",    bus.grant_id,    e_gid);
        check("arb_busy",    bus.arb_busy,    m_phase != 0);
        check("done",        bus.done,        e_done);
        check("timeout_err", bus.timeout_err, e_to);
    end

    task automatic wait_ack(output int g, output logic [DW-1:0] d, output bit ok);
        ok = 1'b0; g = -1; d = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                g  = int'(bus.grant_id);
                d  = bus.tx_data;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.arb_busy && bus.ack == '0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    int             g;
    logic [DW-1:0]  d;
    bit             ok;
    int             starts, acks, cnt;
    bit             seen;
    int             exp_g [5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0]  exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ack",      bus.ack,         '0);
        check("rst_tx_data",  bus.tx_data,     '0);
        check("rst_tx_start", bus.tx_start,    1'b0);
        check("rst_grant_id", bus.grant_id,    '0);
        check("rst_arb_busy", bus.arb_busy,    1'b0);
        check("rst_done",     bus.done,        1'b0);
        check("rst_timeout",  bus.timeout_err, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // Single request, transmitter busy one cycle after start for 10 cycles
        tx_dly = 1; tx_len = 10;
        @(negedge clk);
        bus.req_data[7:0] = 8'hA5;
        bus.req = 4'b0001;
        wait_ack(g, d, ok);
        check("t1_ack_seen", ok, 1'b1);
        check("t1_ack", bus.ack, 4'b0001);
        check("t1_gid", g, 0);
        check("t1_data", d, 8'hA5);
        bus.req = '0;
        starts = int'(bus.tx_start); acks = 0; seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.ack != '0) acks++;
            starts += int'(bus.tx_start);
            if (bus.done) begin seen = 1'b1; break; end
        end
        check("t1_done", seen, 1'b1);
        check("t1_start_cycles", starts, 2);
        check("t1_extra_ack", acks, 0);
        check("t1_gid_hold", bus.grant_id, 0);
        wait_idle("t1_idle");

        // All requesting from a fresh pointer
        do_reset();
        tx_len = 3;
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(g, d, ok);
            check("t2_ack_seen", ok, 1'b1);
            check("t2_order", g, exp_g[i]);
            check("t2_data", d, exp_d[i]);
        end
        bus.req = '0;
        wait_idle("t2_idle");

        // Pointer wrap: grant 3, then 1001 -> 0 then 3
        bus.req = 4'b1000;
        wait_ack(g, d, ok);
        check("t3_first", g, 3);
        bus.req = 4'b1001;
        wait_ack(g, d, ok);
        check("t3_wrap0", g, 0);
        bus.req = 4'b1000;
        wait_ack(g, d, ok);
        check("t3_then3", g, 3);
        bus.req = '0;
        wait_idle("t3_idle");

        // Dead transmitter
        tx_dead = 1'b1;
        bus.req = 4'b0010;
        wait_ack(g, d, ok);
        check("t4_grant", g, 1);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            if (bus.timeout_err) begin seen = 1'b1; break; end
        end
        check("t4_timeout_seen", seen, 1'b1);
        check("t4_timeout_cycles", cnt, 16);
        check("t4_start_low", bus.tx_start, 1'b0);
        check("t4_arb_idle", bus.arb_busy, 1'b0);
        wait_ack(g, d, ok);
        check("t4_regrant", g, 1);
        bus.req = '0;
        tx_dead = 1'b0;
        wait_idle("t4_idle");

        // Reset during SEND
        tx_len = 10;
        bus.req = 4'b0100;
        wait_ack(g, d, ok);
        check("t5_grant", g, 2);
        bus.req = '0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.arb_busy && !bus.tx_start && bus.tx_busy) begin seen = 1'b1; break; end
        end
        check("t5_in_send", seen, 1'b1);
        reset = 1'b0;
        #1;
        check("t5_ack",      bus.ack,         '0);
        check("t5_tx_data",  bus.tx_data,     '0);
        check("t5_tx_start", bus.tx_start,    1'b0);
        check("t5_grant_id", bus.grant_id,    '0);
        check("t5_arb_busy", bus.arb_busy,    1'b0);
        check("t5_done",     bus.done,        1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.req = 4'b1111;
        wait_ack(g, d, ok);
        check("t5_first_after_reset", g, 0);
        bus.req = '0;
        wait_idle("t5_idle");

        // Randomized traffic against the model
        tx_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 1500) begin
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i]) begin
                    if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
                    else bus.req_data[i*DW +: DW] = DW'($urandom);
                end else if (!bus.req[i] && $urandom_range(0, 5) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.req_data[i*DW +: DW] = DW'($urandom);
                end
            end
        end
        bus.req = '0;
        wait_idle("rand_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
